dma_io_channel: RTL and testbench

- Byte-wide I/O peripheral channel sitting directly upstream of the DMA controller; its DREQ feeds the DMA's request input.
- Buffers data in an internal FIFO and drives DREQ. It services DMA strobes: IOR pops a byte onto the shared bus, and IOW captures a byte from the bus.
- Device side is a valid/ready byte stream.
- Direction follows mem_or_io:
  - 1 = IO is source (device -> memory).
  - 0 = memory is source (memory -> device).

---
 rtl/dma_io_pkg.sv | 28 ++
 rtl/dma_io_fifo.sv | 64 ++++++
 rtl/dma_io_channel.sv | 161 ++++++++++++++++
 tb/tb_dma_io_channel.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_io_pkg.sv
// dma_io_pkg: definitions shared by the DMA I/O channel and its FIFO.
//   - state_t        : channel FSM encoding (IDLE, REQ, ACK, GAP)
//   - DIR_*          : direction encodings for mem_or_io / dir
//   - DEFAULT_*      : default FIFO depth and request threshold
//   - req_cond()     : request condition for a direction and FIFO level
package dma_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic DIR_MEM_SRC = 1'b0;
  localparam logic DIR_IO_SRC  = 1'b1;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_THRESH = 1;

  // IO-source: ask the DMA to drain once enough bytes are buffered.
  // Memory-source: ask the DMA to fill while there is room.
  function automatic logic req_cond(input logic d, input int lvl,
                                    input int thresh, input int depth);
    return d ? (lvl >= thresh) : (lvl < depth);
  endfunction

endpackage

// File: rtl/dma_io_fifo.sv
// dma_io_fifo: synchronous byte FIFO with first-word-fall-through head.
// Ports:
//   clk, reset         : clock, synchronous active-high reset (flushes)
//   push, push_data    : write request and data (ignored when full)
//   pop                : read request (ignored when empty)
//   head               : entry at the read pointer, valid when !empty
//   full, empty, level : occupancy status
module dma_io_fifo
  import dma_io_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   level_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_reg == FULL_LVL);
  assign empty   = (level_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign level   = level_reg;
  assign head    = mem[rd_ptr_reg];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage is not reset; flushing the pointers is enough.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/dma_io_channel.sv
// dma_io_channel: byte-wide I/O channel feeding a DMA controller's DREQ.
// Buffers bytes in a FIFO; IOR strobes pop onto the bus (IO source),
// IOW strobes capture the bus (memory source). Device side is valid/ready.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   mem_or_io                  : requested direction (1 = IO source)
//   dreq / dack                : DMA request / acknowledge
//   ior, iow                   : DMA read / write strobes
//   bus_in, bus_out, bus_oe    : shared data bus and output enable
//   dev_in_*                   : device push stream (IO source)
//   dev_out_*                  : device pop stream (memory source)
//   level, dir, err            : occupancy, latched direction, sticky error
// Build option: define DMA_IO_DEMAND_MODE_EN for demand mode (several
// bytes per DREQ); otherwise single mode (one byte, then a GAP cycle).
module dma_io_channel
  import dma_io_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int THRESH = DEFAULT_THRESH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_or_io,
  output logic                   dreq,
  input  logic                   dack,
  input  logic                   ior,
  input  logic                   iow,
  input  logic [7:0]             bus_in,
  output logic [7:0]             bus_out,
  output logic                   bus_oe,
  input  logic                   dev_in_valid,
  input  logic [7:0]             dev_in_data,
  output logic                   dev_in_ready,
  output logic                   dev_out_valid,
  output logic [7:0]             dev_out_data,
  input  logic                   dev_out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   dir,
  output logic                   err
);

  state_t     state_reg;
  state_t     state_next;
  logic       dir_reg;
  logic       err_reg;

  logic [7:0] head;
  logic [7:0] push_data;
  logic       full;
  logic       empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       dev_push;
  logic       dev_pop;
  logic       in_ack;
  logic       strobe_ok;
  logic       bad_strobe;
  logic       dma_pop;
  logic       dma_push;
  logic       overrun;
  logic       reqc;
  int         lvl_now;

  dma_io_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign lvl_now = int'(level);
  assign reqc    = req_cond(dir_reg, lvl_now, THRESH, DEPTH);

  // Device side: only the stream matching the latched direction is live.
  assign dev_in_ready  = ~reset & dir_reg & (lvl_now < DEPTH);
  assign dev_out_valid = ~reset & ~dir_reg & ~empty;
  assign dev_out_data  = dev_out_valid ? head : 8'h00;
  assign dev_push      = dev_in_valid & dev_in_ready;
  assign dev_pop       = dev_out_valid & dev_out_ready;

  // DMA strobes only count while acknowledged in ACK.
  assign in_ack     = (state_reg == ACK);
  assign strobe_ok  = in_ack & dack & (dir_reg ? (ior & ~iow) : (iow & ~ior));
  assign bad_strobe = in_ack & dack & (ior | iow) & ~strobe_ok;
  assign dma_pop    = strobe_ok & dir_reg;
  assign dma_push   = strobe_ok & ~dir_reg;
  // Only reachable when the direction flipped under a pending request.
  assign overrun    = (dma_pop & empty) | (dma_push & full);

  assign fifo_push = dev_push | (dma_push & ~full);
  assign fifo_pop  = dev_pop | (dma_pop & ~empty);
  assign push_data = dir_reg ? dev_in_data : bus_in;

  assign bus_oe  = in_ack & dir_reg & dack & ior;
  assign bus_out = bus_oe ? head : 8'h00;
  assign dir     = dir_reg;
  assign err     = err_reg;

`ifdef DMA_IO_DEMAND_MODE_EN
  // Request condition as it will stand after this edge's transfers.
  int   lvl_after;
  logic reqc_after;
  assign lvl_after  = lvl_now + int'(fifo_push) - int'(fifo_pop);
  assign reqc_after = req_cond(dir_reg, lvl_after, THRESH, DEPTH);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      dir_reg   <= DIR_IO_SRC;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Direction may only change while nothing is buffered or pending.
      if (state_reg == IDLE && empty) dir_reg <= mem_or_io;
      if (bad_strobe | overrun) err_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    dreq       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (reqc) state_next = REQ;
      end
      REQ: begin
        dreq = 1'b1;
        if (dack) state_next = ACK;
      end
      ACK: begin
        dreq = 1'b1;
        if (!dack) begin
          state_next = reqc ? REQ : IDLE;
        end else if (strobe_ok) begin
`ifdef DMA_IO_DEMAND_MODE_EN
          state_next = reqc_after ? ACK : GAP;
`else
          state_next = GAP;
`endif
        end
`ifdef DMA_IO_DEMAND_MODE_EN
        else if (!bad_strobe && !reqc) begin
          state_next = GAP;
        end
`endif
        // A bad strobe leaves the FSM in ACK.
      end
      GAP: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_io_channel.sv
module tb_dma_io_channel;

  localparam int DEPTH  = 8;
  localparam int THRESH = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_or_io;
  logic       dreq;
  logic       dack;
  logic       ior;
  logic       iow;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       dev_in_valid;
  logic [7:0] dev_in_data;
  logic       dev_in_ready;
  logic       dev_out_valid;
  logic [7:0] dev_out_data;
  logic       dev_out_ready;
  logic [3:0] level;
  logic       dir;
  logic       err;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  dma_io_channel #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_or_io     (mem_or_io),
    .dreq          (dreq),
    .dack          (dack),
    .ior           (ior),
    .iow           (iow),
    .bus_in        (bus_in),
    .bus_out       (bus_out),
    .bus_oe        (bus_oe),
    .dev_in_valid  (dev_in_valid),
    .dev_in_data   (dev_in_data),
    .dev_in_ready  (dev_in_ready),
    .dev_out_valid (dev_out_valid),
    .dev_out_data  (dev_out_data),
    .dev_out_ready (dev_out_ready),
    .level         (level),
    .dir           (dir),
    .err           (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic wait_dreq();
    int n = 0;
    while (dreq !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("dreq_wait", 32'(dreq), 1);
  endtask

  // dreq right after a transfer edge: 0 in single mode (GAP); in demand
  // mode it stays up while the request condition still holds.
  task automatic chk_after(input bit d);
    logic exp_dreq;
`ifdef DMA_IO_DEMAND_MODE_EN
    exp_dreq = d ? (sb.size() >= THRESH) : (sb.size() < DEPTH);
`else
    exp_dreq = 1'b0;
`endif
    chk("after_dreq", 32'(dreq), 32'(exp_dreq));
  endtask

  task automatic dev_push(input logic [7:0] d);
    dev_in_valid = 1'b1;
    dev_in_data  = d;
    #1;
    chk("push_ready", 32'(dev_in_ready), 1);
    sb.push_back(d);
    tick();
    dev_in_valid = 1'b0;
  endtask

  task automatic dma_read(input bit with_push, input logic [7:0] pd);
    logic [7:0] exp;
    logic [3:0] lvl_before;
    wait_dreq();
    dack = 1'b1;
    tick();
    ior = 1'b1;
    if (with_push) begin
      dev_in_valid = 1'b1;
      dev_in_data  = pd;
    end
    #1;
    exp        = sb.pop_front();
    lvl_before = level;
    chk("rd_oe", 32'(bus_oe), 1);
    chk("rd_data", 32'(bus_out), 32'(exp));
    if (with_push) begin
      chk("rd_in_ready", 32'(dev_in_ready), 1);
      sb.push_back(pd);
    end
    tick();
    ior = 1'b0;
    dack = 1'b0;
    dev_in_valid = 1'b0;
    #1;
    chk("rd_level", 32'(level), with_push ? 32'(lvl_before) : 32'(lvl_before) - 1);
    chk_after(1'b1);
  endtask

  task automatic dma_write(input logic [7:0] d);
    wait_dreq();
    dack = 1'b1;
    tick();
    iow = 1'b1;
    bus_in = d;
    #1;
    chk("wr_oe", 32'(bus_oe), 0);
    tick();
    iow = 1'b0;
    dack = 1'b0;
    sb.push_back(d);
    #1;
    chk("wr_level", 32'(level), 32'(sb.size()));
    chk_after(1'b0);
  endtask

  initial begin
    logic [7:0] exp;
    reset = 1'b1; mem_or_io = 1'b1; dack = 1'b0; ior = 1'b0; iow = 1'b0;
    bus_in = 8'h00; dev_in_valid = 1'b0; dev_in_data = 8'h00; dev_out_ready = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_level", 32'(level), 0);
    chk("rst_dreq", 32'(dreq), 0);
    chk("rst_oe", 32'(bus_oe), 0);
    chk("rst_bus_out", 32'(bus_out), 0);
    chk("rst_in_ready", 32'(dev_in_ready), 0);
    chk("rst_out_valid", 32'(dev_out_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_dir", 32'(dir), 1);
    reset = 1'b0;
    sb.delete();

    // IO-source single transfer
    dev_push(8'hA5);
    chk("t1_level", 32'(level), 1);
    chk("t1_dreq_lat", 32'(dreq), 0);
    tick();
    chk("t1_dreq", 32'(dreq), 1);
    dma_read(1'b0, 8'h00);
    chk("t1_level0", 32'(level), 0);
    tick();
    chk("t1_idle1", 32'(dreq), 0);
    tick();
    chk("t1_idle2", 32'(dreq), 0);

    // Memory-source fill
    mem_or_io = 1'b0;
    do_reset();
    for (int i = 0; i < DEPTH; i++) dma_write(8'(i));
    chk("t2_dir", 32'(dir), 0);
    chk("t2_level", 32'(level), 8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_dreq_full", 32'(dreq), 0);
    end
    dev_out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp = sb.pop_front();
      chk("t2_out_valid", 32'(dev_out_valid), 1);
      chk("t2_out_data", 32'(dev_out_data), 32'(exp));
      tick();
    end
    dev_out_ready = 1'b0;
    chk("t2_level0", 32'(level), 0);
    chk("t2_out_empty", 32'(dev_out_valid), 0);

    // Wrap-around with concurrent device push and DMA pop
    mem_or_io = 1'b1;
    do_reset();
    dev_push(8'h11);
    dev_push(8'h22);
    for (int i = 0; i < 18; i++) dma_read(1'b1, 8'(8'h30 + i * 7));
    dma_read(1'b0, 8'h00);
    dma_read(1'b0, 8'h00);
    chk("t3_level0", 32'(level), 0);
    chk("t3_err", 32'(err), 0);

    // Protocol error: ior and iow together in ACK
    do_reset();
    dev_push(8'h5C);
    wait_dreq();
    dack = 1'b1;
    tick();
    ior = 1'b1; iow = 1'b1;
    tick();
    ior = 1'b0; iow = 1'b0;
    #1;
    chk("t4_no_pop", 32'(level), 1);
    chk("t4_err", 32'(err), 1);
    chk("t4_in_ack", 32'(dreq), 1);
    tick();
    chk("t4_still_ack", 32'(dreq), 1);
    ior = 1'b1;
    #1;
    exp = sb.pop_front();
    chk("t4_rd_data", 32'(bus_out), 32'(exp));
    tick();
    ior = 1'b0; dack = 1'b0;
    #1;
    chk("t4_level0", 32'(level), 0);
    chk("t4_err_sticky", 32'(err), 1);

    // Reset mid-operation
    do_reset();
    chk("t5_err_clr", 32'(err), 0);
    dev_push(8'h01);
    dev_push(8'h02);
    dev_push(8'h03);
    wait_dreq();
    dack = 1'b1;
    tick();
    chk("t5_level3", 32'(level), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dack = 1'b0;
    sb.delete();
    #1;
    chk("t5_level", 32'(level), 0);
    chk("t5_dreq", 32'(dreq), 0);
    chk("t5_oe", 32'(bus_oe), 0);
    tick();
    chk("t5_idle", 32'(dreq), 0);

`ifdef DMA_IO_DEMAND_MODE_EN
    // Demand mode: three pops under one DREQ
    do_reset();
    dev_push(8'hB1);
    dev_push(8'hB2);
    dev_push(8'hB3);
    wait_dreq();
    dack = 1'b1;
    tick();
    ior = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      exp = sb.pop_front();
      chk("t6_data", 32'(bus_out), 32'(exp));
      tick();
      chk("t6_dreq", 32'(dreq), (k < 2) ? 1 : 0);
    end
    ior = 1'b0; dack = 1'b0;
    tick();
    chk("t6_idle", 32'(dreq), 0);
    chk("t6_level0", 32'(level), 0);
`else
    // Single mode: held strobe still moves only one byte per DREQ
    do_reset();
    dev_push(8'hB1);
    dev_push(8'hB2);
    dev_push(8'hB3);
    wait_dreq();
    dack = 1'b1;
    tick();
    ior = 1'b1;
    #1;
    exp = sb.pop_front();
    chk("t6_data", 32'(bus_out), 32'(exp));
    tick();
    chk("t6_gap_dreq", 32'(dreq), 0);
    chk("t6_level2", 32'(level), 2);
    tick();
    chk("t6_gap_level", 32'(level), 2);
    chk("t6_gap_oe", 32'(bus_oe), 0);
    ior = 1'b0; dack = 1'b0;
    dma_read(1'b0, 8'h00);
    dma_read(1'b0, 8'h00);
    chk("t6_err", 32'(err), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
